// File: rtl/diff_input.sv
// diff_input: captures two 4-bit switch operands on debounced button presses
// and shows their absolute difference and sign.
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   sw     in   [3:0] operand value, sampled only on a press event
//   btn    in   raw confirm button (asynchronous, bouncy)
//   diff   out  [3:0] registered |A-B|
//   sinal  out  registered sign, 1 when A<B
//   valid  out  registered, 1 while diff/sinal hold a result
//   phase  out  [1:0] current state: IDLE=00 WAIT_B=01 CALC=10 SHOW=11
module diff_input #(
   parameter int DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       btn,
   output logic [3:0] diff,
   output logic       sinal,
   output logic       valid,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAIT_B = 2'b01,
      CALC   = 2'b10,
      SHOW   = 2'b11
   } state_t;

   localparam logic [15:0] CNT_MAX = 16'(DEB_CYCLES - 1);

   logic        s1, s2;
   logic        deb, deb_q;
   logic [15:0] cnt;
   logic [1:0]  settle;
   logic        armed;
   logic        press;
   state_t      state, state_n;
   logic [3:0]  a, b;

   // two-flop synchronizer
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   // debounced level follows s2 only after DEB_CYCLES consecutive mismatches
   always_ff @(posedge clk) begin
      if (rst) begin
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         deb_q <= deb;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

   // Events stay disarmed after reset until the synchronizer has flushed and
   // the button is seen released, so a button held through reset release
   // produces nothing until it is let go and pressed again.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle <= 2'd0;
         armed  <= 1'b0;
      end else begin
         if (settle != 2'd3) settle <= settle + 2'd1;
         if (settle == 2'd3 && !s2 && !deb) armed <= 1'b1;
      end
   end

   assign press = armed & deb & ~deb_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (press) state_n = WAIT_B;
         WAIT_B:  if (press) state_n = CALC;
         CALC:    state_n = SHOW;
         SHOW:    if (press) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a     <= 4'd0;
         b     <= 4'd0;
         diff  <= 4'd0;
         sinal <= 1'b0;
         valid <= 1'b0;
      end else begin
         case (state)
            IDLE:   if (press) a <= sw;
            WAIT_B: if (press) b <= sw;
            CALC: begin
               valid <= 1'b1;
               if (a >= b) begin
                  diff  <= a - b;
                  sinal <= 1'b0;
               end else begin
                  diff  <= b - a;
                  sinal <= 1'b1;
               end
            end
            SHOW: if (press) begin
               diff  <= 4'd0;
               sinal <= 1'b0;
               valid <= 1'b0;
            end
            default: begin
               diff  <= 4'd0;
               sinal <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_diff_input.sv
module tb_diff_input;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic       btn;
   logic [3:0] diff;
   logic       sinal, valid;
   logic [1:0] phase;

   int checks = 0;
   int errors = 0;

   // reference model, event-level
   int m_phase, m_a, m_b, m_diff, m_sinal, m_valid;

   diff_input #(.DEB_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn(btn),
      .diff(diff), .sinal(sinal), .valid(valid), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_phase = 0; m_a = 0; m_b = 0; m_diff = 0; m_sinal = 0; m_valid = 0;
   endtask

   task automatic model_event(input int v);
      int d;
      case (m_phase)
         0: begin m_a = v; m_phase = 1; end
         1: begin
            m_b = v;
            d = m_a - m_b;
            m_sinal = (d < 0) ? 1 : 0;
            m_diff = (d < 0) ? -d : d;
            m_valid = 1;
            m_phase = 3;
         end
         default: begin m_diff = 0; m_sinal = 0; m_valid = 0; m_phase = 0; end
      endcase
   endtask

   task automatic do_reset(input int cyc);
      rst = 1'b1;
      repeat (cyc) tick();
      rst = 1'b0;
      model_reset();
   endtask

   // Clean press with sw held; checks event latency and the CALC->SHOW step.
   task automatic do_press(input logic [3:0] v);
      logic [1:0] ph0;
      int lat;
      sw = v;
      ph0 = phase;
      btn = 1'b1;
      lat = 0;
      while (phase === ph0 && lat < 40) begin
         tick();
         lat++;
      end
      model_event(int'(v));
      checks++;
      if (lat < D || lat > D + 5) begin
         errors++;
         $display("FAIL press_latency: got %0d clocks, need %0d..%0d", lat, D, D + 5);
      end
      if (ph0 == 2'b01) begin
         checks++;
         if (phase !== 2'b10 || valid !== 1'b0) begin
            errors++;
            $display("FAIL calc_cycle: phase=%b valid=%b, need phase=10 valid=0", phase, valid);
         end
         tick();
         checks++;
         if ({phase, valid, sinal, diff} !== {2'(m_phase), 1'(m_valid), 1'(m_sinal), 4'(m_diff)}) begin
            errors++;
            $display("FAIL show_latency: phase=%b v=%b s=%b d=%0d, need phase=%0d v=%0d s=%0d d=%0d",
                     phase, valid, sinal, diff, m_phase, m_valid, m_sinal, m_diff);
         end
      end
      repeat (D + 2) tick();
      btn = 1'b0;
      repeat (2 * D + 6) begin
         tick();
         sw = 4'($urandom);
      end
   endtask

   task automatic test_reset();
      btn = 1'b0;
      sw = 4'($urandom);
      do_reset(3);
      checks++;
      if ({phase, valid, sinal, diff} !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: phase=%b v=%b s=%b d=%0d, need all 0", phase, valid, sinal, diff);
      end
      repeat (5) tick();
   endtask

   task automatic test_vectors();
      logic [3:0] va [6] = '{4'd9, 4'd3, 4'd7, 4'd15, 4'd4, 4'd0};
      logic [3:0] vb [6] = '{4'd4, 4'd12, 4'd7, 4'd0, 4'd4, 4'd15};
      for (int i = 0; i < 6; i++) begin
         do_press(va[i]);
         do_press(vb[i]);
         checks++;
         if ({phase, valid, sinal, diff} !== {2'(m_phase), 1'(m_valid), 1'(m_sinal), 4'(m_diff)}) begin
            errors++;
            $display("FAIL vector_%0d: phase=%b v=%b s=%b d=%0d, need phase=%0d v=%0d s=%0d d=%0d",
                     i, phase, valid, sinal, diff, m_phase, m_valid, m_sinal, m_diff);
         end
         do_press(4'($urandom));
         checks++;
         if ({phase, valid, sinal, diff} !== 8'h00) begin
            errors++;
            $display("FAIL clear_%0d: phase=%b v=%b s=%b d=%0d, need all 0", i, phase, valid, sinal, diff);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         do_press(4'($urandom));
         do_press(4'($urandom));
         checks++;
         if ({phase, valid, sinal, diff} !== {2'(m_phase), 1'(m_valid), 1'(m_sinal), 4'(m_diff)}) begin
            errors++;
            $display("FAIL random_%0d: phase=%b v=%b s=%b d=%0d, need phase=%0d v=%0d s=%0d d=%0d",
                     i, phase, valid, sinal, diff, m_phase, m_valid, m_sinal, m_diff);
         end
         do_press(4'($urandom));
      end
   endtask

   task automatic test_bounce();
      do_press(4'd8);
      for (int k = 1; k < D; k++) begin
         btn = 1'b1;
         repeat (k) tick();
         btn = 1'b0;
         repeat (3) tick();
      end
      repeat (2 * D + 6) tick();
      checks++;
      if (phase !== 2'(m_phase) || valid !== 1'b0) begin
         errors++;
         $display("FAIL bounce_no_event: phase=%b valid=%b, need phase=%0d valid=0", phase, valid, m_phase);
      end
      // bouncy leading edge followed by a long clean hold: exactly one event
      btn = 1'b1; tick(); btn = 1'b0; tick();
      btn = 1'b1; tick(); tick(); btn = 1'b0; tick();
      do_press(4'd2);
      checks++;
      if ({phase, valid, sinal, diff} !== {2'(m_phase), 1'(m_valid), 1'(m_sinal), 4'(m_diff)}) begin
         errors++;
         $display("FAIL bounce_one_event: phase=%b v=%b s=%b d=%0d, need phase=%0d v=%0d s=%0d d=%0d",
                  phase, valid, sinal, diff, m_phase, m_valid, m_sinal, m_diff);
      end
      do_press(4'd0);
   endtask

   task automatic test_sw_toggle();
      do_press(4'd11);
      for (int i = 0; i < 30; i++) begin
         sw = 4'($urandom);
         tick();
      end
      do_press(4'd1);
      checks++;
      if ({phase, valid, sinal, diff} !== {2'(m_phase), 1'(m_valid), 1'(m_sinal), 4'(m_diff)}) begin
         errors++;
         $display("FAIL sw_toggle: phase=%b v=%b s=%b d=%0d, need phase=%0d v=%0d s=%0d d=%0d",
                  phase, valid, sinal, diff, m_phase, m_valid, m_sinal, m_diff);
      end
      do_press(4'd0);
   endtask

   task automatic test_mid_reset();
      do_press(4'd5);
      do_reset(1);
      checks++;
      if ({phase, valid, sinal, diff} !== 8'h00) begin
         errors++;
         $display("FAIL reset_in_wait_b: phase=%b v=%b s=%b d=%0d, need all 0", phase, valid, sinal, diff);
      end
      repeat (5) tick();
      do_press(4'd2);
      do_press(4'd6);
      checks++;
      if ({phase, valid, sinal, diff} !== {2'b11, 1'b1, 1'b1, 4'd4}) begin
         errors++;
         $display("FAIL after_reset_calc: phase=%b v=%b s=%b d=%0d, need phase=11 v=1 s=1 d=4",
                  phase, valid, sinal, diff);
      end
      do_reset(1);
      checks++;
      if ({phase, valid, sinal, diff} !== 8'h00) begin
         errors++;
         $display("FAIL reset_in_show: phase=%b v=%b s=%b d=%0d, need all 0", phase, valid, sinal, diff);
      end
      repeat (5) tick();
   endtask

   task automatic test_held_reset();
      btn = 1'b1;
      do_reset(3);
      repeat (4 * D + 10) tick();
      checks++;
      if (phase !== 2'b00) begin
         errors++;
         $display("FAIL held_through_reset: phase=%b, need 00", phase);
      end
      btn = 1'b0;
      repeat (2 * D + 6) tick();
      do_press(4'd13);
      checks++;
      if (phase !== 2'b01) begin
         errors++;
         $display("FAIL press_after_release: phase=%b, need 01", phase);
      end
      do_press(4'd13);
      do_press(4'd0);
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      sw = 4'd0;
      model_reset();
      test_reset();
      test_vectors();
      test_random();
      test_bounce();
      test_sw_toggle();
      test_mid_reset();
      test_held_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/diff_input.md
DIFF_INPUT -- requirements
Module: diff_input

Interface
REQ-001 Parameter DEB_CYCLES, default 16, is the debounce window in clocks; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sw  input  4  unsigned operand value from switches; sampled only on a press event.
REQ-005 btn  input  1  raw confirm button, active-high, asynchronous and bouncy.
REQ-006 diff  output  4  registered magnitude |A-B|, feeding the 7-segment display stage.
REQ-007 sinal  output  1  registered sign: 1 when A<B; feeds the display stage.
REQ-008 valid  output  1  registered; 1 while diff/sinal hold a computed result.
REQ-009 phase  output  2  registered state code: IDLE=00, WAIT_B=01, CALC=10, SHOW=11.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounced level SHALL change only after the synchronized btn differs from it for DEB_CYCLES consecutive clocks; the counter SHALL clear whenever they are equal.
REQ-012 Press event SHALL be a single-cycle pulse on each 0->1 transition of the debounced level; no event on release.
REQ-013 Press event SHALL assert no earlier than DEB_CYCLES and no later than DEB_CYCLES+4 clocks after btn rises cleanly.
REQ-014 Glitches on btn shorter than DEB_CYCLES clocks SHALL produce no event.
REQ-015 IDLE: on event, register A<=sw, go to WAIT_B; otherwise stay.
REQ-016 WAIT_B: on event, register B<=sw, go to CALC; otherwise stay.
REQ-017 CALC: unconditionally, one cycle; register diff and sinal, set valid=1, go to SHOW; events in CALC SHALL be ignored.
REQ-018 Arithmetic: A>=B -> diff=A-B, sinal=0; A<B -> diff=B-A, sinal=1; 4-bit unsigned, never wraps; A=B -> diff=0, sinal=0.
REQ-019 Latency: event in WAIT_B at cycle n -> valid, diff, sinal updated and visible from cycle n+2.
REQ-020 SHOW: diff/sinal/valid SHALL hold stable; on event, clear diff=0, sinal=0, valid=0, go to IDLE.
REQ-021 diff, sinal and valid SHALL be 0 in IDLE, WAIT_B and CALC.
REQ-022 sw changes outside the event cycle SHALL NOT affect A, B or outputs.
REQ-023 phase SHALL reflect the current state register with no combinational path from inputs.
REQ-024 Unused state encodings are impossible by construction; any corrupted state SHALL return to IDLE on the next clock.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, A=B=0, diff=0, sinal=0, valid=0, phase=00, debounce counter=0, synchronizer and debounced level=0.
REQ-026 rst SHALL override any simultaneous press event; the event SHALL be discarded.
REQ-027 Reset asserted mid-operation (WAIT_B, CALC or SHOW) SHALL return to IDLE with all outputs 0 after that edge.
REQ-028 A button held through reset release SHALL NOT generate an event until it is released and pressed again.

Verification
REQ-029 DEB_CYCLES=4; press with sw=9, press with sw=4 -> diff=5, sinal=0, valid=1, phase=11 two clocks after second event.
REQ-030 sw=3 then sw=12 -> diff=9, sinal=1, valid=1; third press -> diff=0, sinal=0, valid=0, phase=00.
REQ-031 sw=7 then sw=7 -> diff=0, sinal=0, valid=1; sw=15 then sw=0 -> diff=15, sinal=0.
REQ-032 btn bounce of 1-3 clock pulses (less than DEB_CYCLES) -> no event, phase unchanged; 10-clock press with bounce at start -> exactly one event.
REQ-033 rst pulsed in WAIT_B after capturing A=5 -> phase=00, outputs 0; subsequent presses sw=2, sw=6 -> diff=4, sinal=1.
REQ-034 sw toggled every clock while in WAIT_B with no press -> A, phase and outputs unchanged.
